// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle WIDTH-bit adder reusing one CHUNK-bit ripple slice
module seq_chunk_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
  localparam int IDXW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % SAFE_CHUNK) != 0) begin : g_bad_params
      $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   add_res;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] sum_next;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // The active slice is located by shifting, so only one CHUNK-bit adder exists.
  always_comb begin
    base       = 32'(idx) * 32'(CHUNK);
    a_chunk    = CHUNK'(opa >> base);
    b_chunk    = CHUNK'(opb >> base);
    add_res    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << base;
    sum_next   = (sum & ~chunk_mask) | ((WIDTH'(add_res[CHUNK-1:0])) << base);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_next;
          carry <= add_res[CHUNK];
          if (idx == LAST_IDX) begin
            cout      <= add_res[CHUNK];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - directed self-checking bench for seq_chunk_adder
module tb_seq_chunk_adder;

  localparam int W = 64;
  localparam int NCH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0]  a, b, sum;
  logic          in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16, busy16;
  logic [15:0]   a16, b16, sum16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(64), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .busy(busy16)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout out_valid=%b required 1", name, out_valid);
    end
  endtask

  task automatic accept(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    int n = 0;
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 0", in_ready);
    end
    checks++;
    if ({out_valid, busy, cout, sum} !== {3'b000, 64'h0}) begin
      errors++;
      $display("FAIL reset_state got ov=%b busy=%b cout=%b sum=%h required 0", out_valid, busy, cout, sum);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_carry_ripple();
    int lat = 0;
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat != NCH) begin
      errors++;
      $display("FAIL ripple_latency got %0d required %0d", lat, NCH);
    end
    checks++;
    if ({cout, sum} !== {1'b1, 64'h0}) begin
      errors++;
      $display("FAIL ripple_result got cout=%b sum=%h required cout=1 sum=0", cout, sum);
    end
    handshake();
  endtask

  task automatic test_operand_change();
    accept(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);
    a = '0;
    b = '0;
    cin = 1'b1;
    wait_out("operand_change");
    checks++;
    if ({cout, sum} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      errors++;
      $display("FAIL operand_change got cout=%b sum=%h required cout=0 sum=ffffffffffffffff", cout, sum);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    accept(64'h1, 64'h2, 1'b1);
    wait_out("backpressure");
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({out_valid, in_ready, busy, cout, sum} !== {3'b101, 1'b0, 64'h4}) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d got ov=%b ir=%b busy=%b cout=%b sum=%h required ov=1 ir=0 busy=1 cout=0 sum=4",
                 i, out_valid, in_ready, busy, cout, sum);
      end
    end
    handshake();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL backpressure_release got ov=%b ir=%b busy=%b required ov=0 ir=1 busy=0", out_valid, in_ready, busy);
    end
    checks++;
    if ({cout, sum} !== {1'b0, 64'h4}) begin
      errors++;
      $display("FAIL backpressure_keep_sum got cout=%b sum=%h required cout=0 sum=4", cout, sum);
    end
  endtask

  task automatic test_reset_mid();
    accept(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_in_ready_during_rst got %b required 0", in_ready);
    end
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, cout, sum} !== {3'b001, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid_state got ov=%b busy=%b ir=%b cout=%b sum=%h required ov=0 busy=0 ir=1 cout=0 sum=0",
               out_valid, busy, in_ready, cout, sum);
    end
    accept(64'd5, 64'd7, 1'b0);
    wait_out("reset_mid_new_add");
    checks++;
    if ({cout, sum} !== {1'b0, 64'd12}) begin
      errors++;
      $display("FAIL reset_mid_new_add got cout=%b sum=%h required cout=0 sum=c", cout, sum);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va, vb;
    logic         vc;
    logic [W:0]   exp;
    int           acc_cyc;
    int           prev_acc = 0;
    int           n;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      va = {$urandom, $urandom};
      vb = {$urandom, $urandom};
      vc = 1'($urandom);
      exp = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
      a = va;
      b = vb;
      cin = vc;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
        step();
        n++;
      end
      acc_cyc = cyc;
      step();
      in_valid = 1'b0;
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev_acc != NCH + 2) begin
          errors++;
          $display("FAIL b2b_gap iter %0d got %0d required %0d", i, acc_cyc - prev_acc, NCH + 2);
        end
      end
      prev_acc = acc_cyc;
      wait_out("b2b");
      checks++;
      if ({cout, sum} !== exp) begin
        errors++;
        $display("FAIL b2b_result iter %0d got %h required %h", i, {cout, sum}, exp);
      end
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_width16();
    logic [15:0] ta [3] = '{16'hFFFF, 16'h1234, 16'h8000};
    logic [15:0] tb [3] = '{16'h0000, 16'h4321, 16'h8000};
    logic        tc [3] = '{1'b1, 1'b0, 1'b1};
    logic [16:0] te [3] = '{17'h1_0000, 17'h0_5555, 17'h1_0001};
    for (int i = 0; i < 3; i++) begin
      a16 = ta[i];
      b16 = tb[i];
      cin16 = tc[i];
      in_valid16 = 1'b1;
      #1;
      checks++;
      if (in_ready16 !== 1'b1) begin
        errors++;
        $display("FAIL w16_in_ready vec %0d got %b required 1", i, in_ready16);
      end
      step();
      in_valid16 = 1'b0;
      a16 = '0;
      b16 = '0;
      step();
      checks++;
      if ({out_valid16, cout16, sum16} !== {1'b1, te[i]}) begin
        errors++;
        $display("FAIL w16_latency1 vec %0d got ov=%b cout=%b sum=%h required ov=1 %h",
                 i, out_valid16, cout16, sum16, te[i]);
      end
      out_ready16 = 1'b1;
      step();
      out_ready16 = 1'b0;
      checks++;
      if ({out_valid16, in_ready16} !== 2'b01) begin
        errors++;
        $display("FAIL w16_release vec %0d got ov=%b ir=%b required ov=0 ir=1", i, out_valid16, in_ready16);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    in_valid16 = 1'b0;
    out_ready16 = 1'b0;
    a16 = '0;
    b16 = '0;
    cin16 = 1'b0;
    test_reset();
    test_carry_ripple();
    test_operand_change();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_width16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
